// File: rtl/control_pkg.sv
// Shared encodings for the hardwired control unit: bus sources, ALU ops, opcodes
// and the bit positions of the register-reference and IO instruction fields.
package control_pkg;

  typedef enum logic [2:0] {
    BUS_NONE, BUS_AR, BUS_PC, BUS_DR, BUS_AC, BUS_IR, BUS_TR, BUS_MEM
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_AND, ALU_ADD, ALU_PASS_DR, ALU_CMA, ALU_NOP, ALU_CIR, ALU_CIL, ALU_RSVD
  } alu_sel_e;

  // OP_XTD (D7) selects register-reference or IO depending on the I bit
  typedef enum logic [2:0] {
    OP_AND, OP_ADD, OP_LDA, OP_STA, OP_BUN, OP_BSA, OP_ISZ, OP_XTD
  } opcode_e;

  localparam int RR_CLA = 11;
  localparam int RR_CLE = 10;
  localparam int RR_CMA = 9;
  localparam int RR_CME = 8;
  localparam int RR_CIR = 7;
  localparam int RR_CIL = 6;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_SZE = 1;
  localparam int RR_HLT = 0;
  localparam int IO_ION = 7;
  localparam int IO_IOF = 6;

  function automatic logic [7:0] decode_op(input logic [2:0] op);
    return 8'b1 << op;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// 3-bit timing-step counter (T0..T6); clear has priority over increment.
module seq_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [2:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= 3'd0;
    else if (clr) count <= 3'd0;
    else if (inc) count <= count + 3'd1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: sequence counter + decoded IR/I/S produce every datapath strobe.
// All strobes are combinational; reset or halt forces them idle (bus 0, ALU NOP).
module control_unit
  import control_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IR,
  input  logic [WIDTH-1:0] AC,
  input  logic [WIDTH-1:0] DR,
  input  logic             E,
  output logic [2:0]       bus_select,
  output logic [2:0]       alu_select,
  output logic             write_En,
  output logic             clr_AC,
  output logic             clr_E,
  output logic             clr_AR,
  output logic             clr_PC,
  output logic             comp_E,
  output logic             ldr_AR,
  output logic             ldr_PC,
  output logic             ldr_IR,
  output logic             ldr_DR,
  output logic             ldr_AC,
  output logic             ldr_TR,
  output logic             inc_AR,
  output logic             inc_AC,
  output logic             inc_DR,
  output logic             inc_PC,
  output logic             set_IEN,
  output logic             clr_IEN,
  output logic [2:0]       sc,
  output logic             halted
);

  logic              i_flag;
  logic              s_flag;
  logic              active;
  logic              sc_clr;
  logic              halt_set;
  logic              skip;
  logic [7:0]        d;
  logic [ADDR_W-1:0] fld;

  assign active = rst_n & s_flag;
  assign d      = decode_op(IR[WIDTH-2 -: 3]);
  assign fld    = IR[ADDR_W-1:0];
  assign halted = ~s_flag;
  assign clr_AR = 1'b0;
  assign clr_PC = 1'b0;
  assign ldr_TR = 1'b0;

  seq_counter u_sc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (s_flag),
    .clr   (sc_clr),
    .count (sc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_flag <= 1'b0;
      s_flag <= 1'b1;
    end else begin
      if (active && sc == 3'd2) i_flag <= IR[WIDTH-1];
      if (halt_set)             s_flag <= 1'b0;
    end
  end

  // Skip tests see AC/E as they were before this instruction's T3 edge
  assign skip = (fld[RR_SPA] & ~AC[WIDTH-1]) | (fld[RR_SNA] & AC[WIDTH-1]) |
                (fld[RR_SZA] & (AC == '0)) | (fld[RR_SZE] & ~E);

  always_comb begin
    bus_select = BUS_NONE;
    alu_select = ALU_NOP;
    {write_En, clr_AC, clr_E, comp_E, ldr_AR, ldr_PC, ldr_IR, ldr_DR, ldr_AC} = '0;
    {inc_AR, inc_AC, inc_DR, inc_PC, set_IEN, clr_IEN} = '0;
    sc_clr   = 1'b0;
    halt_set = 1'b0;
    if (active) begin
      case (sc)
        3'd0: begin bus_select = BUS_PC;  ldr_AR = 1'b1; end
        3'd1: begin bus_select = BUS_MEM; ldr_IR = 1'b1; inc_PC = 1'b1; end
        3'd2: begin bus_select = BUS_IR;  ldr_AR = 1'b1; end
        3'd3: begin
          if (d[OP_XTD]) begin
            sc_clr = 1'b1;
            if (!i_flag) begin
              if (!fld[RR_CLA]) begin
                if (fld[RR_CIR])      alu_select = ALU_CIR;
                else if (fld[RR_CIL]) alu_select = ALU_CIL;
                else if (fld[RR_CMA]) alu_select = ALU_CMA;
                ldr_AC = fld[RR_CIR] | fld[RR_CIL] | fld[RR_CMA];
                inc_AC = fld[RR_INC];
              end
              clr_AC   = fld[RR_CLA];
              clr_E    = fld[RR_CLE];
              comp_E   = fld[RR_CME] & ~fld[RR_CLE];
              inc_PC   = skip;
              halt_set = fld[RR_HLT];
            end else begin
              set_IEN = fld[IO_ION];
              clr_IEN = fld[IO_IOF];
            end
          end else if (i_flag) begin
            bus_select = BUS_MEM;
            ldr_AR     = 1'b1;
          end
        end
        3'd4: begin
          if (d[OP_AND] | d[OP_ADD] | d[OP_LDA] | d[OP_ISZ]) begin
            bus_select = BUS_MEM; ldr_DR = 1'b1;
          end else if (d[OP_STA]) begin
            bus_select = BUS_AC; write_En = 1'b1; sc_clr = 1'b1;
          end else if (d[OP_BUN]) begin
            bus_select = BUS_AR; ldr_PC = 1'b1; sc_clr = 1'b1;
          end else if (d[OP_BSA]) begin
            bus_select = BUS_PC; write_En = 1'b1; inc_AR = 1'b1;
          end else begin
            sc_clr = 1'b1;
          end
        end
        3'd5: begin
          if (d[OP_AND] | d[OP_ADD] | d[OP_LDA]) begin
            alu_select = d[OP_AND] ? ALU_AND : (d[OP_ADD] ? ALU_ADD : ALU_PASS_DR);
            ldr_AC = 1'b1; sc_clr = 1'b1;
          end else if (d[OP_BSA]) begin
            bus_select = BUS_AR; ldr_PC = 1'b1; sc_clr = 1'b1;
          end else if (d[OP_ISZ]) begin
            inc_DR = 1'b1;
          end else begin
            sc_clr = 1'b1;
          end
        end
        3'd6: begin
          if (d[OP_ISZ]) begin
            bus_select = BUS_DR; write_En = 1'b1; inc_PC = (DR == '0);
          end
          sc_clr = 1'b1;
        end
        default: sc_clr = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks fetch, memory-ref, reg-ref, IO, reset and halt sequences.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] IR, AC, DR;
  logic        E;
  logic [2:0]  bus_select, alu_select, sc;
  logic write_En, clr_AC, clr_E, clr_AR, clr_PC, comp_E, ldr_AR, ldr_PC, ldr_IR, ldr_DR;
  logic ldr_AC, ldr_TR, inc_AR, inc_AC, inc_DR, inc_PC, set_IEN, clr_IEN, halted;

  int errors = 0;
  int checks = 0;

  localparam logic [17:0] M_WR = 18'h1 << 17, M_CLRAC = 18'h1 << 16, M_CLRE = 18'h1 << 15;
  localparam logic [17:0] M_COMPE = 18'h1 << 12, M_LDAR = 18'h1 << 11, M_LDPC = 18'h1 << 10;
  localparam logic [17:0] M_LDIR = 18'h1 << 9, M_LDDR = 18'h1 << 8, M_LDAC = 18'h1 << 7;
  localparam logic [17:0] M_INCAR = 18'h1 << 5, M_INCAC = 18'h1 << 4, M_INCDR = 18'h1 << 3;
  localparam logic [17:0] M_INCPC = 18'h1 << 2, M_SIEN = 18'h1 << 1, M_CIEN = 18'h1;
  localparam logic [23:0] REST = {3'd0, 3'd4, 18'd0};

  logic [23:0] ctl;
  assign ctl = {bus_select, alu_select, write_En, clr_AC, clr_E, clr_AR, clr_PC, comp_E,
                ldr_AR, ldr_PC, ldr_IR, ldr_DR, ldr_AC, ldr_TR, inc_AR, inc_AC, inc_DR,
                inc_PC, set_IEN, clr_IEN};

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .IR(IR), .AC(AC), .DR(DR), .E(E),
    .bus_select(bus_select), .alu_select(alu_select), .write_En(write_En),
    .clr_AC(clr_AC), .clr_E(clr_E), .clr_AR(clr_AR), .clr_PC(clr_PC), .comp_E(comp_E),
    .ldr_AR(ldr_AR), .ldr_PC(ldr_PC), .ldr_IR(ldr_IR), .ldr_DR(ldr_DR), .ldr_AC(ldr_AC),
    .ldr_TR(ldr_TR), .inc_AR(inc_AR), .inc_AC(inc_AC), .inc_DR(inc_DR), .inc_PC(inc_PC),
    .set_IEN(set_IEN), .clr_IEN(clr_IEN), .sc(sc), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ex(input logic [2:0] b, input logic [2:0] a,
                                     input logic [17:0] m);
    return {b, a, m};
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock step: check sc and the control word mid-cycle, then move past the next edge
  task automatic cyc(input string tag, input logic [2:0] esc, input logic [23:0] ectl);
    @(negedge clk);
    chk({tag, " sc"}, {21'd0, sc}, {21'd0, esc});
    chk({tag, " ctl"}, ctl, ectl);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [15:0] ir);
    cyc({tag, " T0"}, 3'd0, ex(3'd2, 3'd4, M_LDAR));
    cyc({tag, " T1"}, 3'd1, ex(3'd7, 3'd4, M_LDIR | M_INCPC));
    IR = ir;
    cyc({tag, " T2"}, 3'd2, ex(3'd5, 3'd4, M_LDAR));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; IR = 16'h0000; AC = 16'h0000; DR = 16'h0000; E = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset sc", {21'd0, sc}, 24'd0);
    chk("reset ctl", ctl, REST);
    chk("reset halted", {23'd0, halted}, 24'd0);
    rst_n = 1'b1;

    fetch("CLA", 16'h7800);
    cyc("CLA T3", 3'd3, ex(3'd0, 3'd4, M_CLRAC));

    AC = 16'hFFFF;
    fetch("ADD", 16'h1005);
    cyc("ADD T3", 3'd3, REST);
    cyc("ADD T4", 3'd4, ex(3'd7, 3'd4, M_LDDR));
    cyc("ADD T5", 3'd5, ex(3'd0, 3'd1, M_LDAC));

    fetch("LDAi", 16'hA010);
    cyc("LDAi T3", 3'd3, ex(3'd7, 3'd4, M_LDAR));
    cyc("LDAi T4", 3'd4, ex(3'd7, 3'd4, M_LDDR));
    cyc("LDAi T5", 3'd5, ex(3'd0, 3'd2, M_LDAC));

    fetch("AND", 16'h0003);
    cyc("AND T3", 3'd3, REST);
    cyc("AND T4", 3'd4, ex(3'd7, 3'd4, M_LDDR));
    cyc("AND T5", 3'd5, ex(3'd0, 3'd0, M_LDAC));

    DR = 16'hFFFF;
    fetch("ISZ0", 16'h6020);
    cyc("ISZ0 T3", 3'd3, REST);
    cyc("ISZ0 T4", 3'd4, ex(3'd7, 3'd4, M_LDDR));
    cyc("ISZ0 T5", 3'd5, ex(3'd0, 3'd4, M_INCDR));
    DR = 16'h0000;
    cyc("ISZ0 T6", 3'd6, ex(3'd3, 3'd4, M_WR | M_INCPC));

    DR = 16'h0004;
    fetch("ISZ5", 16'h6020);
    cyc("ISZ5 T3", 3'd3, REST);
    cyc("ISZ5 T4", 3'd4, ex(3'd7, 3'd4, M_LDDR));
    cyc("ISZ5 T5", 3'd5, ex(3'd0, 3'd4, M_INCDR));
    DR = 16'h0005;
    cyc("ISZ5 T6", 3'd6, ex(3'd3, 3'd4, M_WR));

    fetch("BSA", 16'h5030);
    cyc("BSA T3", 3'd3, REST);
    cyc("BSA T4", 3'd4, ex(3'd2, 3'd4, M_WR | M_INCAR));
    cyc("BSA T5", 3'd5, ex(3'd1, 3'd4, M_LDPC));

    fetch("STA", 16'h3007);
    cyc("STA T3", 3'd3, REST);
    cyc("STA T4", 3'd4, ex(3'd4, 3'd4, M_WR));

    fetch("BUN", 16'h4009);
    cyc("BUN T3", 3'd3, REST);
    cyc("BUN T4", 3'd4, ex(3'd1, 3'd4, M_LDPC));

    fetch("CIRCME", 16'h7180);
    cyc("CIRCME T3", 3'd3, ex(3'd0, 3'd5, M_LDAC | M_COMPE));
    fetch("CLECMA", 16'h7600);
    cyc("CLECMA T3", 3'd3, ex(3'd0, 3'd3, M_LDAC | M_CLRE));
    fetch("CLECME", 16'h7500);
    cyc("CLECME T3", 3'd3, ex(3'd0, 3'd4, M_CLRE));
    fetch("CLAMIX", 16'h7A20);
    cyc("CLAMIX T3", 3'd3, ex(3'd0, 3'd4, M_CLRAC));
    fetch("CILCMA", 16'h7260);
    cyc("CILCMA T3", 3'd3, ex(3'd0, 3'd6, M_LDAC | M_INCAC));

    AC = 16'h0001; E = 1'b1;
    fetch("SPA", 16'h7010);
    cyc("SPA T3", 3'd3, ex(3'd0, 3'd4, M_INCPC));
    fetch("SNA", 16'h7008);
    cyc("SNA T3", 3'd3, REST);
    AC = 16'h0000;
    fetch("SZASZE", 16'h7006);
    cyc("SZASZE T3", 3'd3, ex(3'd0, 3'd4, M_INCPC));
    fetch("SZE", 16'h7002);
    cyc("SZE T3", 3'd3, REST);

    fetch("ION", 16'hF080);
    cyc("ION T3", 3'd3, ex(3'd0, 3'd4, M_SIEN));
    fetch("IOF", 16'hF040);
    cyc("IOF T3", 3'd3, ex(3'd0, 3'd4, M_CIEN));

    fetch("ADDrst", 16'h1005);
    cyc("ADDrst T3", 3'd3, REST);
    cyc("ADDrst T4", 3'd4, ex(3'd7, 3'd4, M_LDDR));
    chk("ADDrst T5 sc", {21'd0, sc}, 24'd5);
    chk("ADDrst T5 ctl", ctl, ex(3'd0, 3'd1, M_LDAC));
    rst_n = 1'b0;
    #2;
    chk("rst mid sc", {21'd0, sc}, 24'd0);
    chk("rst mid ctl", ctl, REST);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    fetch("HLT", 16'h7001);
    cyc("HLT T3", 3'd3, REST);
    for (int i = 0; i < 20; i++) begin
      chk("halted flag", {23'd0, halted}, 24'd1);
      cyc("halted", 3'd0, REST);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
